// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types and defaults for the pipeline controller.
//   state_t      : controller FSM states
//   stage_ctrl_t : hold/clear pair driven into one pipeline register
//   cnt_width    : width helper for counters that must hold 0..max_val
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    HALTED,
    STEP
  } state_t;

  localparam int DEF_DRAIN_CYCLES = 4;
  localparam int DEF_MEM_TIMEOUT  = 64;

  typedef struct packed {
    logic stall;
    logic zero;
  } stage_ctrl_t;

  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// hazard_detect: combinational load-use comparator.
//   Inputs : ID source registers with their use flags, EX load flag and
//            EX destination register.
//   Output : load_use - the ID instruction needs the result of the load in EX.
// Register 0 is hard-wired zero, so a load targeting it never creates a hazard.
module hazard_detect #(
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rd,
  output logic             load_use
);

  logic rs_hit;
  logic rt_hit;

  assign rs_hit   = id_uses_rs && (id_rs == ex_rd);
  assign rt_hit   = id_uses_rt && (id_rt == ex_rd);
  assign load_use = ex_mem_read && (ex_rd != '0) && (rs_hit || rt_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central pipeline controller for the 5-stage core.
//   clock, reset         : single clock, synchronous active-high reset
//   id_*, ex_mem_read,
//   ex_rd                : load-use hazard inputs
//   ex_branch_taken      : taken branch resolved in EX
//   mem_req, mem_ready   : multi-cycle data memory handshake
//   halt_req, step_req   : debug halt (level) / single step (pulse)
//   pc_hold, *_stall,
//   *_zero               : combinational pipeline register controls
//   halt_ack             : pipeline drained and frozen
//   mem_err              : sticky memory timeout flag
//   stall_cnt, flush_cnt : saturating performance counters
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W        = 5,
  parameter int MEM_TIMEOUT  = DEF_MEM_TIMEOUT,
  parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES,
  parameter int CNT_W        = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             halt_req,
  input  logic             step_req,
  output logic             pc_hold,
  output logic             if_id_stall,
  output logic             if_id_zero,
  output logic             id_ex_stall,
  output logic             id_ex_zero,
  output logic             ex_mem_stall,
  output logic             ex_mem_zero,
  output logic             mem_wb_zero,
  output logic             halt_ack,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int DW = cnt_width(DRAIN_CYCLES);
  localparam int WW = cnt_width(MEM_TIMEOUT);

  state_t          state_reg, state_next;
  logic [DW-1:0]   drain_cnt_reg, drain_cnt_next;
  logic [WW-1:0]   wait_cnt_reg, wait_cnt_next;
  logic            mem_err_reg;
  logic [CNT_W-1:0] stall_cnt_reg, flush_cnt_reg;

  logic        load_use;
  logic        mem_wait;
  logic        branch_eff;
  logic        load_use_eff;
  stage_ctrl_t if_id_c, id_ex_c, ex_mem_c;

  hazard_detect #(.REG_W(REG_W)) u_hazard (
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rs  (id_uses_rs),
    .id_uses_rt  (id_uses_rt),
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .load_use    (load_use)
  );

  // A memory wait freezes everything, so a branch sitting in EX is simply
  // held and resolves on the first ready cycle.
  assign mem_wait     = mem_req && !mem_ready;
  assign branch_eff   = ex_branch_taken && !mem_wait;
  assign load_use_eff = load_use && !mem_wait && !ex_branch_taken;

  // Control outputs
  always_comb begin
    pc_hold     = 1'b0;
    if_id_c     = '0;
    id_ex_c     = '0;
    ex_mem_c    = '0;
    mem_wb_zero = 1'b0;
    halt_ack    = 1'b0;
    if (reset) begin
      pc_hold       = 1'b1;
      if_id_c.zero  = 1'b1;
      id_ex_c.zero  = 1'b1;
      ex_mem_c.zero = 1'b1;
      mem_wb_zero   = 1'b1;
    end else begin
      if (mem_wait) begin
        pc_hold        = 1'b1;
        if_id_c.stall  = 1'b1;
        id_ex_c.stall  = 1'b1;
        ex_mem_c.stall = 1'b1;
        mem_wb_zero    = 1'b1;
      end else if (branch_eff) begin
        if_id_c.zero = 1'b1;
        id_ex_c.zero = 1'b1;
      end else if (load_use_eff) begin
        pc_hold       = 1'b1;
        if_id_c.stall = 1'b1;
        id_ex_c.zero  = 1'b1;
      end
      // Drain/halt feed bubbles into IF_ID, but an instruction being held
      // by a hazard stall must not be wiped out.
      if (state_reg == DRAIN && !branch_eff) pc_hold = 1'b1;
      if (state_reg == HALTED) pc_hold = 1'b1;
      if ((state_reg == DRAIN || state_reg == HALTED) && !if_id_c.stall)
        if_id_c.zero = 1'b1;
      halt_ack = (state_reg == HALTED);
    end
  end

  assign if_id_stall  = if_id_c.stall;
  assign if_id_zero   = if_id_c.zero;
  assign id_ex_stall  = id_ex_c.stall;
  assign id_ex_zero   = id_ex_c.zero;
  assign ex_mem_stall = ex_mem_c.stall;
  assign ex_mem_zero  = ex_mem_c.zero;

  // Next-state logic
  always_comb begin
    state_next     = state_reg;
    drain_cnt_next = drain_cnt_reg;
    case (state_reg)
      RUN: begin
        if (halt_req) begin
          state_next     = DRAIN;
          drain_cnt_next = DW'(DRAIN_CYCLES);
        end
      end
      DRAIN: begin
        if (!halt_req) begin
          state_next     = RUN;
          drain_cnt_next = '0;
        end else if (!mem_wait) begin
          // The last bubble cycle is the one that moves us to HALTED, so
          // exactly DRAIN_CYCLES non-stalled cycles are spent here.
          if (drain_cnt_reg <= DW'(1)) begin
            state_next     = HALTED;
            drain_cnt_next = '0;
          end else begin
            drain_cnt_next = drain_cnt_reg - 1'b1;
          end
        end
      end
      HALTED: begin
        if (!halt_req)     state_next = RUN;
        else if (step_req) state_next = STEP;
      end
      STEP: begin
        if (!mem_wait) begin
          state_next     = DRAIN;
          drain_cnt_next = DW'(DRAIN_CYCLES);
        end
      end
      default: begin
        state_next     = RUN;
        drain_cnt_next = '0;
      end
    endcase
  end

  // Consecutive memory-wait tracking; saturates at the timeout value.
  always_comb begin
    wait_cnt_next = '0;
    if (mem_wait) begin
      if (wait_cnt_reg != WW'(MEM_TIMEOUT)) wait_cnt_next = wait_cnt_reg + 1'b1;
      else                                  wait_cnt_next = wait_cnt_reg;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= RUN;
      drain_cnt_reg <= '0;
      wait_cnt_reg  <= '0;
      mem_err_reg   <= 1'b0;
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      drain_cnt_reg <= drain_cnt_next;
      wait_cnt_reg  <= wait_cnt_next;
      if (wait_cnt_next == WW'(MEM_TIMEOUT)) mem_err_reg <= 1'b1;
      // Only hazard stalls count; holds caused by halting do not.
      if ((mem_wait || load_use_eff) && stall_cnt_reg != '1)
        stall_cnt_reg <= stall_cnt_reg + 1'b1;
      if (branch_eff && flush_cnt_reg != '1)
        flush_cnt_reg <= flush_cnt_reg + 1'b1;
    end
  end

  assign mem_err   = mem_err_reg;
  assign stall_cnt = stall_cnt_reg;
  assign flush_cnt = flush_cnt_reg;

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Central pipeline controller for the 5-stage core. It drives the zero (flush) and stall inputs of the IF_ID, ID_EX, EX_MEM and MEM_WB pipeline registers and the PC hold. Its decisions come from load-use hazards, taken branches, multi-cycle memory accesses and a debug halt/single-step handshake. It also keeps saturating performance counters and a sticky memory-timeout error flag.

## Interface
Parameters:
- REG_W, 5, register index width
- MEM_TIMEOUT, 64, consecutive memory-wait cycles before mem_err is set
- DRAIN_CYCLES, 4, non-stalled bubble cycles needed to empty IF_ID..MEM_WB
- CNT_W, 16, performance counter width

Ports:
- clock  in  1  single clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- id_rs, id_rt  in  REG_W  source registers of the instruction in ID
- id_uses_rs, id_uses_rt  in  1  ID instruction reads rs / rt
- ex_mem_read  in  1  instruction in EX is a load
- ex_rd  in  REG_W  destination register of the EX instruction
- ex_branch_taken  in  1  branch resolved taken in EX this cycle
- mem_req  in  1  MEM-stage instruction accesses data memory
- mem_ready  in  1  data memory completes this cycle
- halt_req  in  1  debug halt request (level)
- step_req  in  1  single-step pulse, honoured only in HALTED
- pc_hold  out  1  PC keeps its value
- if_id_stall, if_id_zero  out  1  IF_ID hold / clear
- id_ex_stall, id_ex_zero  out  1  ID_EX hold / clear
- ex_mem_stall, ex_mem_zero  out  1  EX_MEM hold / clear
- mem_wb_zero  out  1  MEM_WB clear (bubble into WB)
- halt_ack  out  1  pipeline empty and frozen
- mem_err  out  1  sticky memory timeout
- stall_cnt, flush_cnt  out  CNT_W  saturating counters

## Operation
Control signals are combinational from the inputs and the current state. Priority is as follows, highest first:
- Reset: while reset=1, pc_hold=1, every *_zero=1, every *_stall=0.
- Memory wait (mem_req & ~mem_ready):
  - pc_hold=1, if_id_stall=1, id_ex_stall=1, ex_mem_stall=1, mem_wb_zero=1.
  - Branch and load-use decisions are suppressed.
- Branch flush (ex_branch_taken):
  - if_id_zero=1, id_ex_zero=1, pc_hold=0 so the PC loads the target.
  - Load-use is suppressed.
- Load-use: condition is ex_mem_read & ex_rd≠0 & ((id_uses_rs & id_rs==ex_rd) | (id_uses_rt & id_rt==ex_rd)).
  - Response: pc_hold=1, if_id_stall=1, id_ex_zero=1.
- Otherwise all outputs are 0.

State machine (RUN, DRAIN, HALTED, STEP):
- RUN → DRAIN when halt_req=1.
- DRAIN: pc_hold=1 (except on a branch flush), if_id_zero=1. The drain counter is loaded with DRAIN_CYCLES on entry and decrements only on cycles with no memory wait. At 0 → HALTED.
- HALTED: halt_ack=1, pc_hold=1, if_id_zero=1.
  - halt_req=0 → RUN.
  - step_req=1 → STEP.
- STEP: a single cycle with pc_hold=0 and if_id_zero=0, which admits one instruction. Then → DRAIN, which reloads the counter.
  - During a memory wait, STEP holds its state until the wait ends.
- halt_req dropped during DRAIN: return to RUN next cycle.

Counters and error flag:
- stall_cnt increments on each cycle where pc_hold=1 because of a memory wait or load-use (not halt).
- flush_cnt increments on each branch-flush cycle.
- Both counters saturate at all-ones and clear only on reset.
- A wait counter counts consecutive memory-wait cycles and clears when there is no wait. When it reaches MEM_TIMEOUT, mem_err is set. mem_err stays set until reset. The stall continues regardless.

## Timing
- Zero latency for all control outputs. State, counters and mem_err update on the clock edge, with a 1-cycle delay to visibility.
- Reset values: state=RUN, drain counter=0, halt_ack=0, mem_err=0, stall_cnt=0, flush_cnt=0.
- Reset asserted mid-DRAIN or mid-wait: the state returns to RUN next edge, and no counter is retained.
- Branch and memory wait in the same cycle: the memory wait wins. The branch remains held in EX and is taken on the first ready cycle.
- step_req outside HALTED is ignored. step_req coinciding with halt_req=0 in HALTED: RUN wins.
- Load-use against ex_rd=0 never stalls.

## Structure
- Package pipe_ctrl_pkg holds:
  - the state enum {RUN, DRAIN, HALTED, STEP}
  - the default constants DRAIN_CYCLES and MEM_TIMEOUT
  - a typedef for the stage-control bundle (stall/zero per register)
- Sub-module hazard_detect: a purely combinational load-use comparator with output load_use. All other logic lives in pipe_ctrl.

## Test plan
- Load-use: ex_mem_read=1, ex_rd=3, id_rs=3, id_uses_rs=1 → pc_hold=1, if_id_stall=1, id_ex_zero=1 for that cycle; stall_cnt 0→1.
- Branch flush with hazard: ex_branch_taken=1 plus a load-use match → if_id_zero=1, id_ex_zero=1, pc_hold=0; flush_cnt=1, stall_cnt unchanged.
- Memory wait: mem_req=1, mem_ready=0 for 5 cycles while ex_branch_taken=1 → 5 cycles of freeze with mem_wb_zero=1, then one flush cycle; stall_cnt=5, flush_cnt=1.
- Timeout: with MEM_TIMEOUT=8, hold mem_ready=0 for 10 cycles → mem_err rises at the edge after cycle 8 and stays 1 after mem_ready; reset clears it.
- Halt/step: halt_req=1 with no stalls → halt_ack=1 after 4 DRAIN cycles. Then step_req pulse → exactly one cycle with pc_hold=0, then halt_ack=1 again 4 cycles later. Then halt_req=0 → RUN, outputs all 0.
- Reset mid-DRAIN: reset=1 at drain count 2 → all *_zero=1 and pc_hold=1 during reset; after release, state is RUN and halt_ack=0.
